i2c_bus_frontend: RTL

Upstream conditioning stage for i2c_slave_controller. It samples raw SCL/SDA pad inputs on the system clock and passes them through a synchronizer and a glitch filter. It produces filtered line levels, single-cycle SCL edge strobes and START/STOP/repeated-START strobes, and tracks bus busy/idle with an SCL-low timeout. The slave controller consumes these strobes instead of clocking on the raw line.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_line_filter.sv | 48 ++++
 rtl/i2c_bus_frontend.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and default parameters for the I2C bus front end.
package i2c_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    localparam int unsigned I2C_SYNC_STAGES    = 2;
    localparam int unsigned I2C_FILTER_CYCLES  = 3;
    localparam int unsigned I2C_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus glitch filter for one open-drain I2C line (idles high).
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = I2C_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = I2C_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out,
    output logic settled
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign settled = (cnt_q == '0);

    // Metastability chain; resets to the released (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    // Filtered level only follows the synced level after it has differed for FILTER_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_out <= 1'b1;
            cnt_q    <= '0;
        end else if (synced == line_out) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
            line_out <= synced;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C bus front end: filtered SCL/SDA, edge strobes, START/STOP detection,
// bus busy tracking and SCL-low timeout for the slave controller.
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = I2C_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES  = I2C_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic out_scl,
    output logic out_sda,
    output logic out_scl_rise,
    output logic out_scl_fall,
    output logic out_start,
    output logic out_rep_start,
    output logic out_stop,
    output logic out_bus_busy,
    output logic out_timeout
);

    localparam int unsigned ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES;
    localparam int unsigned ACW        = $clog2(ARM_CYCLES + 1);
    localparam int unsigned TCW        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic           scl_settled;
    logic           sda_settled;
    logic           scl_prev_q;
    logic           sda_prev_q;
    logic           armed_q;
    logic [ACW-1:0] arm_cnt_q;
    logic [TCW-1:0] to_cnt_q;
    bus_state_t     state_q;

    logic           arm_ok;
    logic           start_det;
    logic           stop_det;
    logic           timeout_hit;

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (scl_in),
        .line_out (out_scl),
        .settled  (scl_settled)
    );

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk      (clk),
        .rst      (rst),
        .line_in  (sda_in),
        .line_out (out_sda),
        .settled  (sda_settled)
    );

    // Bus conditions from previous/current filtered levels; START has priority over the timeout.
    always_comb begin
        arm_ok      = out_scl && out_sda && scl_settled && sda_settled;
        start_det   = armed_q && scl_prev_q && out_scl && sda_prev_q && !out_sda;
        stop_det    = armed_q && scl_prev_q && out_scl && !sda_prev_q && out_sda;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !out_scl
                      && (to_cnt_q == TCW'(TIMEOUT_CYCLES)) && !start_det;
    end

    // Previous filtered levels and registered SCL edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            out_scl_rise <= 1'b0;
            out_scl_fall <= 1'b0;
        end else begin
            scl_prev_q   <= out_scl;
            sda_prev_q   <= out_sda;
            out_scl_rise <= out_scl && !scl_prev_q;
            out_scl_fall <= !out_scl && scl_prev_q;
        end
    end

    // Arm condition detection only once the bus has been quietly idle long enough; a timeout disarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
        end else if (timeout_hit) begin
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
        end else if (!arm_ok) begin
            arm_cnt_q <= '0;
        end else if (!armed_q) begin
            if (arm_cnt_q == ACW'(ARM_CYCLES - 1)) begin
                armed_q <= 1'b1;
            end else begin
                arm_cnt_q <= arm_cnt_q + 1'b1;
            end
        end
    end

    // IDLE/BUSY tracking, condition strobes and the saturating SCL-low timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            out_start     <= 1'b0;
            out_rep_start <= 1'b0;
            out_stop      <= 1'b0;
            out_timeout   <= 1'b0;
            out_bus_busy  <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            out_start     <= start_det;
            out_rep_start <= start_det && (state_q == BUSY);
            out_stop      <= stop_det;
            out_timeout   <= timeout_hit;
            out_bus_busy  <= (state_q == BUSY);
            if (start_det) begin
                state_q  <= BUSY;
                to_cnt_q <= '0;
            end else if (stop_det || timeout_hit) begin
                state_q  <= IDLE;
                to_cnt_q <= '0;
            end else if ((state_q == BUSY) && !out_scl) begin
                if ((TIMEOUT_CYCLES != 0) && (to_cnt_q != TCW'(TIMEOUT_CYCLES))) begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

endmodule
